// File: rtl/sync_qual_pkg.sv
// -----------------------------------------------------------------------------
// sync_qual_pkg
// Shared types and helpers for sync_bus_qualifier.
//   state_e   : qualifier FSM state. bit0 = settling, bit1 = pending, so each
//               status output is one state bit.
//   cnt_width : width of the stability counter for a given STABLE_CYC.
//   sat_inc   : saturating increment for counters up to 32 bits wide.
// -----------------------------------------------------------------------------
package sync_qual_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'b00,
        SETTLE      = 2'b01,
        PEND        = 2'b10,
        PEND_SETTLE = 2'b11
    } state_e;

    // The counter must be able to hold STABLE_CYC itself, because it saturates there.
    function automatic int cnt_width(input int stable_cyc);
        return (stable_cyc < 1) ? 1 : $clog2(stable_cyc + 1);
    endfunction

    // Increment val and clamp it at the all-ones value of a width-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input int width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (val >= max_val) ? max_val : (val + 32'd1);
    endfunction

endpackage

// File: rtl/sync_qual_stab_cnt.sv
// -----------------------------------------------------------------------------
// sync_qual_stab_cnt
// Tracks how long d_sync has held the same code.
// The optional glitch output exists only when SYNC_QUAL_GLITCH_CNT_EN is defined.
// Ports:
//   clk, rstn : clock and asynchronous active-low reset
//   d_sync    : synchronized bus
//   stable    : d_sync matches the previous sample, and the next edge is the
//               STABLE_CYC-th consecutive matching sample (qualify candidate)
//   abandon   : (SYNC_QUAL_GLITCH_CNT_EN only) a partly settled value changed
//               before it qualified
// -----------------------------------------------------------------------------
module sync_qual_stab_cnt
    import sync_qual_pkg::*;
#(
    parameter int                 WIDTH      = 8,
    parameter int                 STABLE_CYC = 3,
    parameter logic [WIDTH-1:0]   RESET_VAL  = '0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [WIDTH-1:0]  d_sync,
    output logic              stable
`ifdef SYNC_QUAL_GLITCH_CNT_EN
    ,output logic             abandon
`endif
);

    localparam int            CW       = cnt_width(STABLE_CYC);
    localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYC);
    localparam logic [CW-1:0] CNT_QUAL = CW'(STABLE_CYC - 1);

    logic [WIDTH-1:0] prev_q, prev_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             same;

    always_comb begin
        same   = (d_sync == prev_q);
        prev_d = d_sync;
        cnt_d  = cnt_q;
        if (!same) begin
            cnt_d = '0;
        end else if (cnt_q < CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prev_q <= RESET_VAL;
            cnt_q  <= '0;
        end else begin
            prev_q <= prev_d;
            cnt_q  <= cnt_d;
        end
    end

    assign stable = same && (cnt_q == CNT_QUAL);

`ifdef SYNC_QUAL_GLITCH_CNT_EN
    // A count of zero means the value was only just seen. A change at that point
    // is ordinary skew and is not counted as an abandoned value.
    assign abandon = !same && (cnt_q != '0) && (cnt_q < CNT_MAX);
`endif

endmodule

// File: rtl/sync_bus_qualifier.sv
// -----------------------------------------------------------------------------
// sync_bus_qualifier
// Qualifies a synchronized multi-bit bus. A code is released only after it has
// been seen for STABLE_CYC consecutive samples and differs from the last
// released code. Released codes go to a one-entry valid/ready output register.
// A newer code overwrites an unaccepted one, and each overwrite is counted in
// drop_cnt.
// Optional macro SYNC_QUAL_GLITCH_CNT_EN adds the glitch_cnt output, which
// counts settling values abandoned before they qualified.
//
// state       | meaning
// ------------+-----------------------------------------------
// IDLE        | bus equals last release, nothing pending
// SETTLE      | bus differs from last release, nothing pending
// PEND        | bus equals last release, q_data awaiting accept
// PEND_SETTLE | bus differs from last release, q_data pending
//
// Ports:
//   clk, rstn   : clock and asynchronous active-low reset
//   d_sync      : synchronized bus input
//   q_data      : released value (holds the last released value at all times)
//   q_valid     : released value awaiting acceptance
//   q_ready     : consumer accepts on q_valid & q_ready at posedge
//   settle_busy : bus differs from the last release and has not yet qualified
//   drop_cnt    : saturating count of overwritten, unaccepted values
//   glitch_cnt  : (SYNC_QUAL_GLITCH_CNT_EN only) saturating abandoned-value count
// -----------------------------------------------------------------------------
module sync_bus_qualifier
    import sync_qual_pkg::*;
#(
    parameter int                 WIDTH      = 8,
    parameter int                 STABLE_CYC = 3,
    parameter logic [WIDTH-1:0]   RESET_VAL  = '0,
    parameter int                 DROP_W     = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [WIDTH-1:0]  d_sync,
    output logic [WIDTH-1:0]  q_data,
    output logic              q_valid,
    input  logic              q_ready,
    output logic              settle_busy,
    output logic [DROP_W-1:0] drop_cnt
`ifdef SYNC_QUAL_GLITCH_CNT_EN
    ,output logic [DROP_W-1:0] glitch_cnt
`endif
);

    logic              stable;
    logic              qualify;
    logic              pending;
    logic              pending_d;
    logic              settling_d;
    logic [WIDTH-1:0]  last_q_q, last_q_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
    state_e            state_q, state_d;

`ifdef SYNC_QUAL_GLITCH_CNT_EN
    logic              abandon;
    logic [DROP_W-1:0] glitch_cnt_q, glitch_cnt_d;
`endif

    sync_qual_stab_cnt #(
        .WIDTH      (WIDTH),
        .STABLE_CYC (STABLE_CYC),
        .RESET_VAL  (RESET_VAL)
    ) u_stab_cnt (
        .clk    (clk),
        .rstn   (rstn),
        .d_sync (d_sync),
        .stable (stable)
`ifdef SYNC_QUAL_GLITCH_CNT_EN
        ,.abandon (abandon)
`endif
    );

    always_comb begin
        pending    = (state_q == PEND) || (state_q == PEND_SETTLE);
        qualify    = stable && (d_sync != last_q_q);
        last_q_d   = last_q_q;
        pending_d  = pending;
        drop_cnt_d = drop_cnt_q;

        // A qualify event beats the accept. If nobody takes the old value, it is lost.
        if (qualify) begin
            last_q_d  = d_sync;
            pending_d = 1'b1;
            if (pending && !q_ready) begin
                drop_cnt_d = DROP_W'(sat_inc(32'(drop_cnt_q), DROP_W));
            end
        end else if (pending && q_ready) begin
            pending_d = 1'b0;
        end

        // The state describes the situation after this edge, so settle_busy
        // drops on the same edge that raises q_valid.
        settling_d = (d_sync != last_q_d);
        state_d    = IDLE;
        case ({pending_d, settling_d})
            2'b00:   state_d = IDLE;
            2'b01:   state_d = SETTLE;
            2'b10:   state_d = PEND;
            default: state_d = PEND_SETTLE;
        endcase
    end

`ifdef SYNC_QUAL_GLITCH_CNT_EN
    always_comb begin
        glitch_cnt_d = glitch_cnt_q;
        if (abandon) begin
            glitch_cnt_d = DROP_W'(sat_inc(32'(glitch_cnt_q), DROP_W));
        end
    end
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            last_q_q   <= RESET_VAL;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            last_q_q   <= last_q_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

`ifdef SYNC_QUAL_GLITCH_CNT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            glitch_cnt_q <= '0;
        end else begin
            glitch_cnt_q <= glitch_cnt_d;
        end
    end
    assign glitch_cnt = glitch_cnt_q;
`endif

    // The output register and the last released value are always loaded
    // together, so one flop bank serves both.
    assign q_data      = last_q_q;
    assign q_valid     = (state_q == PEND) || (state_q == PEND_SETTLE);
    assign settle_busy = (state_q == SETTLE) || (state_q == PEND_SETTLE);
    assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_sync_bus_qualifier.sv
module tb_sync_bus_qualifier;

    logic       clk = 1'b0;
    logic       rstn;
    logic [7:0] d_sync;
    logic       q_ready;
    logic [7:0] q_data;
    logic       q_valid;
    logic       settle_busy;
    logic [7:0] drop_cnt;
`ifdef SYNC_QUAL_GLITCH_CNT_EN
    logic [7:0] glitch_cnt;
`endif

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_v;

    sync_bus_qualifier #(
        .WIDTH      (8),
        .STABLE_CYC (3),
        .RESET_VAL  (8'h00),
        .DROP_W     (8)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .d_sync      (d_sync),
        .q_data      (q_data),
        .q_valid     (q_valid),
        .q_ready     (q_ready),
        .settle_busy (settle_busy),
        .drop_cnt    (drop_cnt)
`ifdef SYNC_QUAL_GLITCH_CNT_EN
        ,.glitch_cnt (glitch_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; d_sync = 8'h00; q_ready = 1'b1;
        #1;
        checks++; if (q_valid !== 1'b0) begin failures++; $display("FAIL rst_q_valid: got %b want 0", q_valid); end
        checks++; if (q_data !== 8'h00) begin failures++; $display("FAIL rst_q_data: got %h want 00", q_data); end
        checks++; if (settle_busy !== 1'b0) begin failures++; $display("FAIL rst_settle_busy: got %b want 0", settle_busy); end
        checks++; if (drop_cnt !== 8'h00) begin failures++; $display("FAIL rst_drop_cnt: got %h want 00", drop_cnt); end
        tick(); tick();
        rstn = 1'b1;
        for (int t = 1; t <= 10; t++) begin
            tick();
            checks++; if (q_valid !== 1'b0) begin failures++; $display("FAIL idle_q_valid t=%0d: got %b want 0", t, q_valid); end
            checks++; if (settle_busy !== 1'b0) begin failures++; $display("FAIL idle_settle_busy t=%0d: got %b want 0", t, settle_busy); end
        end
        checks++; if (drop_cnt !== 8'h00) begin failures++; $display("FAIL idle_drop_cnt: got %h want 00", drop_cnt); end
    endtask

    task automatic test_single_value();
        logic ev, es;
        d_sync = 8'hA5; q_ready = 1'b1;
        exp_q.push_back(8'hA5);
        for (int t = 1; t <= 6; t++) begin
            tick();
            ev = (t == 4);
            es = (t <= 3);
            checks++; if (q_valid !== ev) begin failures++; $display("FAIL single_q_valid t=%0d: got %b want %b", t, q_valid, ev); end
            checks++; if (settle_busy !== es) begin failures++; $display("FAIL single_settle_busy t=%0d: got %b want %b", t, settle_busy, es); end
            if (q_valid && q_ready) begin
                checks++;
                if (exp_q.size() == 0) begin failures++; $display("FAIL single_sb_extra: got q_data=%h want no emission", q_data); end
                else begin
                    exp_v = exp_q.pop_front();
                    if (q_data !== exp_v) begin failures++; $display("FAIL single_sb_data: got %h want %h", q_data, exp_v); end
                end
            end
        end
    endtask

    task automatic test_glitch();
        logic [7:0] seq [6];
        logic       ev;
        seq = '{8'h3C, 8'h3C, 8'h7C, 8'h3C, 8'h3C, 8'h3C};
        q_ready = 1'b1;
        exp_q.push_back(8'h3C);
        for (int t = 1; t <= 9; t++) begin
            if (t <= 6) d_sync = seq[t-1];
            tick();
            ev = (t == 7);
            checks++; if (q_valid !== ev) begin failures++; $display("FAIL glitch_q_valid t=%0d: got %b want %b", t, q_valid, ev); end
            if (q_valid && q_ready) begin
                checks++;
                if (exp_q.size() == 0) begin failures++; $display("FAIL glitch_sb_extra: got q_data=%h want no emission", q_data); end
                else begin
                    exp_v = exp_q.pop_front();
                    if (q_data !== exp_v) begin failures++; $display("FAIL glitch_sb_data: got %h want %h", q_data, exp_v); end
                end
            end
        end
`ifdef SYNC_QUAL_GLITCH_CNT_EN
        checks++; if (glitch_cnt !== 8'd1) begin failures++; $display("FAIL glitch_cnt: got %0d want 1", glitch_cnt); end
`endif
    endtask

    task automatic test_drop();
        q_ready = 1'b0;
        d_sync  = 8'h11;
        for (int t = 1; t <= 4; t++) tick();
        checks++; if (q_valid !== 1'b1) begin failures++; $display("FAIL drop_first_valid: got %b want 1", q_valid); end
        checks++; if (q_data !== 8'h11) begin failures++; $display("FAIL drop_first_data: got %h want 11", q_data); end
        checks++; if (settle_busy !== 1'b0) begin failures++; $display("FAIL drop_first_settle: got %b want 0", settle_busy); end
        d_sync = 8'h22;
        exp_q.push_back(8'h22);
        for (int t = 1; t <= 3; t++) begin
            tick();
            checks++; if (q_data !== 8'h11) begin failures++; $display("FAIL drop_hold_data t=%0d: got %h want 11", t, q_data); end
            checks++; if (settle_busy !== 1'b1) begin failures++; $display("FAIL drop_hold_settle t=%0d: got %b want 1", t, settle_busy); end
        end
        tick();
        checks++; if (q_valid !== 1'b1) begin failures++; $display("FAIL drop_second_valid: got %b want 1", q_valid); end
        checks++; if (drop_cnt !== 8'd1) begin failures++; $display("FAIL drop_cnt: got %0d want 1", drop_cnt); end
        checks++; if (settle_busy !== 1'b0) begin failures++; $display("FAIL drop_second_settle: got %b want 0", settle_busy); end
        q_ready = 1'b1;
        if (q_valid && q_ready) begin
            checks++;
            if (exp_q.size() == 0) begin failures++; $display("FAIL drop_sb_extra: got q_data=%h want no emission", q_data); end
            else begin
                exp_v = exp_q.pop_front();
                if (q_data !== exp_v) begin failures++; $display("FAIL drop_sb_data: got %h want %h", q_data, exp_v); end
            end
        end
        tick();
        checks++; if (q_valid !== 1'b0) begin failures++; $display("FAIL drop_accept_valid: got %b want 0", q_valid); end
    endtask

    task automatic test_back_to_back();
        q_ready = 1'b0;
        d_sync  = 8'h11;
        exp_q.push_back(8'h11);
        for (int t = 1; t <= 4; t++) tick();
        checks++; if (q_valid !== 1'b1) begin failures++; $display("FAIL b2b_first_valid: got %b want 1", q_valid); end
        d_sync = 8'h44;
        exp_q.push_back(8'h44);
        tick(); tick(); tick();
        q_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            if (k == 1) begin
                tick();
                checks++; if (q_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid_kept: got %b want 1", q_valid); end
                checks++; if (drop_cnt !== 8'd1) begin failures++; $display("FAIL b2b_drop_cnt: got %0d want 1", drop_cnt); end
            end
            if (q_valid && q_ready) begin
                checks++;
                if (exp_q.size() == 0) begin failures++; $display("FAIL b2b_sb_extra: got q_data=%h want no emission", q_data); end
                else begin
                    exp_v = exp_q.pop_front();
                    if (q_data !== exp_v) begin failures++; $display("FAIL b2b_sb_data k=%0d: got %h want %h", k, q_data, exp_v); end
                end
            end else begin
                checks++; failures++;
                $display("FAIL b2b_no_transfer k=%0d: got q_valid=%b want 1", k, q_valid);
            end
        end
        tick();
        checks++; if (q_valid !== 1'b0) begin failures++; $display("FAIL b2b_final_valid: got %b want 0", q_valid); end
    endtask

    task automatic test_reset_mid_settle();
        logic ev;
        q_ready = 1'b1;
        d_sync  = 8'hF0;
        tick(); tick();
        rstn = 1'b0;
        #1;
        checks++; if (q_valid !== 1'b0) begin failures++; $display("FAIL mrst_q_valid: got %b want 0", q_valid); end
        checks++; if (q_data !== 8'h00) begin failures++; $display("FAIL mrst_q_data: got %h want 00", q_data); end
        checks++; if (settle_busy !== 1'b0) begin failures++; $display("FAIL mrst_settle_busy: got %b want 0", settle_busy); end
        checks++; if (drop_cnt !== 8'h00) begin failures++; $display("FAIL mrst_drop_cnt: got %h want 00", drop_cnt); end
        tick(); tick();
        checks++; if ({q_valid, settle_busy, q_data} !== 10'd0) begin failures++; $display("FAIL mrst_held: got %b want 0", {q_valid, settle_busy, q_data}); end
        rstn = 1'b1;
        exp_q.push_back(8'hF0);
        for (int t = 1; t <= 6; t++) begin
            tick();
            ev = (t == 4);
            checks++; if (q_valid !== ev) begin failures++; $display("FAIL mrst_q_valid t=%0d: got %b want %b", t, q_valid, ev); end
            if (q_valid && q_ready) begin
                checks++;
                if (exp_q.size() == 0) begin failures++; $display("FAIL mrst_sb_extra: got q_data=%h want no emission", q_data); end
                else begin
                    exp_v = exp_q.pop_front();
                    if (q_data !== exp_v) begin failures++; $display("FAIL mrst_sb_data: got %h want %h", q_data, exp_v); end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_value();
        test_glitch();
        test_drop();
        test_back_to_back();
        test_reset_mid_settle();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover: got %0d pending expected values want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
